// File: rtl/st7789_window_streamer.sv
// st7789_window_streamer: ST7789 init sequence plus windowed RGB565 writer over SCL/SDA/DC.
// Panel reset/init logic is built only when `ST7789_INIT_EN is defined.
module st7789_window_streamer #(
  parameter int         CLK_DIV  = 2,
  parameter int         WIDTH    = 240,
  parameter int         HEIGHT   = 240,
  parameter int         X_OFS    = 0,
  parameter int         Y_OFS    = 0,
  parameter logic [7:0] MADCTL   = 8'h00,
  parameter int         RST_CYC  = 10000,
  parameter int         WAIT_CYC = 200000
) (
  input  logic        w_clk,
  input  logic        w_rst_n,
  input  logic        start,
  input  logic [7:0]  x0,
  input  logic [7:0]  x1,
  input  logic [7:0]  y0,
  input  logic [7:0]  y1,
  input  logic [15:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic        st7789_SCL,
  output logic        st7789_SDA,
  output logic        st7789_DC,
  output logic        st7789_RES,
  output logic        busy,
  output logic        frame_done,
  output logic        err
);
  typedef enum logic [3:0] {
    INIT_RES_LO, INIT_RES_HI, INIT_CMD, INIT_WAIT, IDLE, HDR, PIX_HI, PIX_LO, DONE
  } state_t;
  localparam logic [7:0]  DIV_M1 = 8'(CLK_DIV - 1);
  localparam logic [8:0]  W_LIM  = 9'(WIDTH);
  localparam logic [8:0]  H_LIM  = 9'(HEIGHT);
  localparam logic [15:0] XO     = 16'(X_OFS);
  localparam logic [15:0] YO     = 16'(Y_OFS);
`ifdef ST7789_INIT_EN
  localparam state_t      RST_ST = INIT_RES_LO;
  localparam logic [31:0] RST_T  = 32'(RST_CYC);
  localparam logic [31:0] WAIT_T = 32'(WAIT_CYC);
`else
  localparam state_t      RST_ST = IDLE;
`endif
  if (CLK_DIV < 1 || CLK_DIV > 255 || RST_CYC < 1 || WAIT_CYC < 1) begin : g_bad_cfg
    $error("st7789_window_streamer: CLK_DIV, RST_CYC or WAIT_CYC out of range");
  end
  state_t      state, state_nx;
  logic        eng_busy, ld, ok;
  logic [8:0]  ld_byte, dx, dy;
  logic [6:0]  sh;
  logic [2:0]  bit_cnt;
  logic [7:0]  div, wx0, wx1, wy0, wy1, pix_lo;
  logic [3:0]  idx;
  logic [16:0] pcnt;
  logic [15:0] hx0, hx1, hy0, hy1;
  assign dx  = {1'b0, x1} - {1'b0, x0} + 9'd1;
  assign dy  = {1'b0, y1} - {1'b0, y0} + 9'd1;
  assign ok  = x0 <= x1 && {1'b0, x1} < W_LIM && y0 <= y1 && {1'b0, y1} < H_LIM;
  assign hx0 = {8'h00, wx0} + XO;
  assign hx1 = {8'h00, wx1} + XO;
  assign hy0 = {8'h00, wy0} + YO;
  assign hy1 = {8'h00, wy1} + YO;
  // Byte engine: every SCL fall (including the load) shifts out the next bit; one idle cycle ends each byte.
  always_ff @(posedge w_clk or negedge w_rst_n)
    if (!w_rst_n) begin
      eng_busy   <= 1'b0;
      st7789_SCL <= 1'b1;
      st7789_SDA <= 1'b0;
      st7789_DC  <= 1'b0;
      sh         <= '0;
      bit_cnt    <= '0;
      div        <= '0;
    end else if (!eng_busy) begin
      if (ld) begin
        eng_busy   <= 1'b1;
        st7789_SCL <= 1'b0;
        st7789_DC  <= ld_byte[8];
        st7789_SDA <= ld_byte[7];
        sh         <= ld_byte[6:0];
        bit_cnt    <= 3'd7;
        div        <= DIV_M1;
      end
    end else if (div != 8'd0) div <= div - 8'd1;
    else if (!st7789_SCL) begin
      st7789_SCL <= 1'b1;
      div        <= DIV_M1;
    end else if (bit_cnt != 3'd0) begin
      st7789_SCL <= 1'b0;
      st7789_SDA <= sh[6];
      sh         <= {sh[5:0], 1'b0};
      bit_cnt    <= bit_cnt - 3'd1;
      div        <= DIV_M1;
    end else eng_busy <= 1'b0;
`ifdef ST7789_INIT_EN
  logic [31:0] tmr;
  // INIT_WAIT only counts once the preceding command byte has fully left the wire.
  always_ff @(posedge w_clk or negedge w_rst_n)
    if (!w_rst_n) begin
      tmr        <= '0;
      st7789_RES <= 1'b1;
    end else begin
      tmr        <= (state_nx != state) ? 32'd0 : (state == INIT_WAIT && eng_busy) ? tmr : tmr + 32'd1;
      st7789_RES <= state_nx != INIT_RES_LO;
    end
`else
  assign st7789_RES = 1'b1;
`endif
  always_ff @(posedge w_clk or negedge w_rst_n)
    if (!w_rst_n) begin
      state  <= RST_ST;
      idx    <= '0;
      pcnt   <= '0;
      wx0    <= '0;
      wx1    <= '0;
      wy0    <= '0;
      wy1    <= '0;
      pix_lo <= '0;
      err    <= 1'b0;
    end else begin
      state <= state_nx;
      idx   <= (state == IDLE) ? 4'd0 : ld ? idx + 4'd1 : idx;
      err   <= state == IDLE && start && !ok;
      if (state == IDLE && start) begin
        wx0  <= x0;
        wx1  <= x1;
        wy0  <= y0;
        wy1  <= y1;
        pcnt <= {8'h00, dx} * {8'h00, dy};
      end else if (state == PIX_LO && ld) pcnt <= pcnt - 17'd1;
      if (state == PIX_HI && ld) pix_lo <= pix_data[7:0];
    end
  always_comb begin
    state_nx = state;
    case (state)
`ifdef ST7789_INIT_EN
      INIT_RES_LO: state_nx = (tmr == RST_T) ? INIT_RES_HI : state;
      INIT_RES_HI: state_nx = (tmr == RST_T - 32'd1) ? INIT_CMD : state;
      INIT_CMD:    state_nx = (!eng_busy && idx == 4'd9) ? IDLE : (ld && idx <= 4'd1) ? INIT_WAIT : state;
      INIT_WAIT:   state_nx = (!eng_busy && tmr == WAIT_T - 32'd1) ? INIT_CMD : state;
`endif
      IDLE:        state_nx = (start && ok) ? HDR : state;
      HDR:         state_nx = (ld && idx == 4'd10) ? PIX_HI : state;
      PIX_HI:      state_nx = ld ? PIX_LO : state;
      PIX_LO:      state_nx = ld ? ((pcnt == 17'd1) ? DONE : PIX_HI) : state;
      DONE:        state_nx = eng_busy ? state : IDLE;
      default:     state_nx = RST_ST;
    endcase
  end
  always_comb begin
    ld      = 1'b0;
    ld_byte = 9'h000;
    case (state)
      INIT_CMD: begin
        ld = !eng_busy && idx != 4'd9;
        case (idx)
          4'd0:    ld_byte = 9'h001;
          4'd1:    ld_byte = 9'h011;
          4'd2:    ld_byte = 9'h03A;
          4'd3:    ld_byte = 9'h155;
          4'd4:    ld_byte = 9'h036;
          4'd5:    ld_byte = {1'b1, MADCTL};
          4'd6:    ld_byte = 9'h021;
          4'd7:    ld_byte = 9'h013;
          default: ld_byte = 9'h029;
        endcase
      end
      HDR: begin
        ld = !eng_busy;
        case (idx)
          4'd0:    ld_byte = 9'h02A;
          4'd1:    ld_byte = {1'b1, hx0[15:8]};
          4'd2:    ld_byte = {1'b1, hx0[7:0]};
          4'd3:    ld_byte = {1'b1, hx1[15:8]};
          4'd4:    ld_byte = {1'b1, hx1[7:0]};
          4'd5:    ld_byte = 9'h02B;
          4'd6:    ld_byte = {1'b1, hy0[15:8]};
          4'd7:    ld_byte = {1'b1, hy0[7:0]};
          4'd8:    ld_byte = {1'b1, hy1[15:8]};
          4'd9:    ld_byte = {1'b1, hy1[7:0]};
          default: ld_byte = 9'h02C;
        endcase
      end
      PIX_HI: begin
        ld      = !eng_busy && pix_valid;
        ld_byte = {1'b1, pix_data[15:8]};
      end
      PIX_LO: begin
        ld      = !eng_busy;
        ld_byte = {1'b1, pix_lo};
      end
      default: ld = 1'b0;
    endcase
    pix_ready  = state == PIX_HI && !eng_busy;
    frame_done = state == DONE && !eng_busy;
    busy       = !(state == IDLE || frame_done);
  end
endmodule
